// File: rtl/id_ex_lanes_if.sv
// Decode-to-execute bus for the ID/EX pipeline register: one issue group of
// LANES instructions with ready/valid handshakes on both sides.
interface id_ex_lanes_if #(
    parameter int LANES = 2,
    parameter int DW    = 32,
    parameter int PCW   = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [PCW-1:0]        in_pc;
    logic [LANES*DW-1:0]   in_instr;
    logic [LANES-1:0]      in_lane_valid;

    logic                  out_valid;
    logic                  out_ready;
    logic [PCW-1:0]        out_pc;
    logic [LANES*DW-1:0]   out_instr;
    logic [LANES-1:0]      out_lane_valid;

    logic                  flush;
    logic [LANES-1:0]      kill_lanes;
    logic [1:0]            occupancy;

    // Pipeline register side.
    modport slave (
        input  in_valid, in_pc, in_instr, in_lane_valid,
        output in_ready,
        output out_valid, out_pc, out_instr, out_lane_valid,
        input  out_ready,
        input  flush, kill_lanes,
        output occupancy
    );

    // Decode/execute side, as seen by whoever drives the register.
    modport master (
        output in_valid, in_pc, in_instr, in_lane_valid,
        input  in_ready,
        input  out_valid, out_pc, out_instr, out_lane_valid,
        output out_ready,
        output flush, kill_lanes,
        input  occupancy
    );
endinterface

// File: rtl/id_ex_lanes.sv
// ID/EX pipeline register for LANES issue slots: main slot plus one-entry skid
// so in_ready comes straight from a flop. Supports flush, lane kill and squash.
module id_ex_lanes #(
    parameter int LANES = 2,
    parameter int DW    = 32,
    parameter int PCW   = 32
) (
    input logic         clk,
    input logic         reset,
    id_ex_lanes_if.slave bus
);

    typedef struct packed {
        logic                valid;
        logic [PCW-1:0]      pc;
        logic [LANES*DW-1:0] instr;
        logic [LANES-1:0]    lane_valid;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    slot_t main_q, main_d;
    slot_t skid_q, skid_d;
    slot_t in_slot;
    logic  accept;
    logic  drain;

    // An all-invalid group still handshakes but is never stored.
    assign accept = bus.in_valid & ~skid_q.valid & ~bus.flush & (|bus.in_lane_valid);
    assign drain  = main_q.valid & bus.out_ready;

    always_comb begin
        in_slot = '{valid: 1'b1, pc: bus.in_pc, instr: bus.in_instr,
                    lane_valid: bus.in_lane_valid};
        // NOTE: every next-state value is defaulted to its current value first,
        // so no path through this block can leave a latch behind.
        main_d = main_q;
        skid_d = skid_q;

        if (bus.flush) begin
            main_d = SLOT_EMPTY;
            skid_d = SLOT_EMPTY;
        end else begin
            if (!main_q.valid || drain) begin
                if (skid_q.valid) begin
                    main_d = skid_q;
                    if (accept) skid_d = in_slot;
                    else        skid_d.valid = 1'b0;
                end else if (accept) begin
                    main_d = in_slot;
                end else begin
                    main_d.valid = 1'b0;
                end
            end else if (accept) begin
                skid_d = in_slot;
            end

            // Killed groups stay valid and issue as bubbles.
            if (main_d.valid) main_d.lane_valid = main_d.lane_valid & ~bus.kill_lanes;
            if (skid_d.valid) skid_d.lane_valid = skid_d.lane_valid & ~bus.kill_lanes;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: payload fields are reset too, not just the valid bits, because
        // out_* must read zero straight after reset.
        if (reset) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            main_q <= SLOT_EMPTY;
            skid_q <= SLOT_EMPTY;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign bus.in_ready       = ~skid_q.valid;
    assign bus.out_valid      = main_q.valid;
    assign bus.out_pc         = main_q.pc;
    assign bus.out_instr      = main_q.instr;
    assign bus.out_lane_valid = main_q.lane_valid;
    assign bus.occupancy      = {1'b0, main_q.valid} + {1'b0, skid_q.valid};

endmodule

// File: doc/id_ex_lanes.md
# id_ex_lanes

Parametrised ID/EX pipeline register for the superscalar datapath, generalising the fixed dual-issue latch to LANES issue slots. It carries one issue group (PC plus LANES instructions with per-lane valid bits) from decode to execute. Ready/valid handshaking and a one-entry skid buffer make `in_ready` a pure register output, so back-pressure from execute never forms a combinational path into decode. Flush, per-lane kill and all-invalid-group squash are supported.

## Interface
- LANES, 2, issue slots per group (≥1)
- DW, 32, instruction width per lane
- PCW, 32, PC width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode presents a group
- in_ready  out  1  block can accept; equals ~skid_valid (register-driven)
- in_pc  in  PCW  group PC
- in_instr  in  LANES*DW  lane i at [i*DW +: DW]
- in_lane_valid  in  LANES  per-lane valid
- out_valid  out  1  group held for execute
- out_ready  in  1  execute consumes
- out_pc  out  PCW  held PC
- out_instr  out  LANES*DW  held instructions
- out_lane_valid  out  LANES  held lane valids, post-kill
- flush  in  1  discard all held and incoming groups
- kill_lanes  in  LANES  clear the matching lane-valid bits in held groups
- occupancy  out  2  groups held (0..2)

## Operation
- Storage: main slot (drives out_*), skid slot. Each slot has valid, pc, instr, lane_valid.
- Accept = in_valid & in_ready & ~flush & (|in_lane_valid). A group with in_lane_valid == 0 completes the handshake but is dropped (squash).
- Drain = out_valid & out_ready.
- Per-cycle update, priority order:
  1. reset: both slots invalid, all payload fields 0.
  2. flush: both slots invalid, payload 0. Incoming beat discarded.
  3. Otherwise:
     - Main empty or draining: main ← skid if skid valid, else ← input if Accept, else main becomes invalid with payload held.
     - Main loaded from skid and Accept: skid ← input.
     - Main loaded from skid, no Accept: skid invalid.
     - Main full, not draining, Accept: skid ← input. Cannot overflow, because in_ready = 0 whenever the skid is valid.
- kill_lanes: applied on the same edge to every slot that remains or becomes valid. stored lane_valid ← lane_valid & ~kill_lanes, including a group being written from input that cycle.
  - A held group whose lane_valid becomes all-zero through kill stays valid. It still issues as a bubble; only incoming groups are squashed.
- occupancy = main.valid + skid.valid.
- out_valid = main.valid. out_* show main payload even when invalid (held or 0).

## Timing
- Latency: an accepted group appears on out_* the next cycle if main was empty or draining. Otherwise one cycle after the main slot drains.
- Throughput: one group per cycle with out_ready held high.
- in_ready: deasserts the cycle after a stall fills the skid. It reasserts the cycle after the skid moves into main.
- Reset values: out_valid 0, out_pc 0, out_instr 0, out_lane_valid 0, occupancy 0, in_ready 1 on the first cycle after reset.
- Flush and reset take effect on the same edge. After either, the next edge can accept a new group.
- Flush while occupancy = 2 and out_ready = 1: the drain still counts as a handshake for execute that cycle. Both slots are cleared.
- Reset asserted mid-stall overrides all other inputs.

## Test plan
- Streaming: LANES=2, out_ready=1. Send pc 0x100/0x108/0x110 with instr {0xA,0xB}, {0xC,0xD}, {0xE,0xF}, lane_valid 2'b11. Expect each on out_* exactly one cycle later, in order, with occupancy ≤1.
- Stall and skid: hold out_ready=0 and send 0x100 and 0x108. Expect occupancy=2 and in_ready=0 the next cycle. Raise out_ready: expect 0x100 then 0x108 on consecutive cycles, in_ready=1 one cycle after the first drain, and no loss or duplication.
- Squash: send in_lane_valid=2'b00 at pc 0x200. Expect the handshake to complete, out_valid to stay 0 and occupancy 0. A following 2'b01 group at 0x204 must appear with out_lane_valid=2'b01.
- Kill: with 0x300 (2'b11) held under stall, pulse kill_lanes=2'b10. Expect out_lane_valid=2'b01 next cycle, out_valid still 1, pc unchanged.
- Flush: with occupancy=2, assert flush together with in_valid at 0x400. Expect out_valid=0, occupancy=0, out_pc=0 and in_ready=1 next cycle, and 0x400 never issued.
- Reset: assert reset mid-stream with occupancy=2. Expect all outputs at reset values next cycle. Repeat with LANES=4, DW=16 to check lane slicing of in_instr[i*DW +: DW].
